// File: rtl/keypad_scan_ctrl.sv
// Keypad scan sequencer: paces the active-low column drive, debounces whole 3-column
// frames and emits one key_valid (or key_error) pulse one cycle after the deciding frame.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scan_en,
   input  logic [3:0] row,
   output logic [2:0] column,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic       key_error
);
   localparam int         CW      = $clog2(SCAN_DIV);
   localparam logic [3:0] DB      = 4'(DEBOUNCE);
   localparam logic [2:0] COL_A   = 3'b110;
   localparam logic [2:0] COL_C   = 3'b011;
   localparam logic [2:0] COL_OFF = 3'b111;

   typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;
   typedef enum logic [1:0] {IDLE, PRESSED, BLOCKED} state_t;

   logic [3:0]    row_s1_q, row_s1_d, row_s2_q, row_s2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    column_q, column_d;
   res_t          acc_res_q, acc_res_d, prev_res_q, prev_res_d;
   logic [3:0]    acc_code_q, acc_code_d, prev_code_q, prev_code_d;
   logic          frame_done_q, frame_done_d;
   logic [3:0]    stab_q, stab_d;
   state_t        state_q, state_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          key_held_q, key_held_d;
   logic          key_error_q, key_error_d;

   res_t          samp_res, base_res;
   logic [3:0]    samp_code;
   logic          match, evt;

   function automatic logic [3:0] key_map(input logic [2:0] col, input logic [3:0] r);
      logic [3:0] code;
      code = 4'd0;
      case ({col, r})
         7'b110_0111: code = 4'd11;
         7'b110_1011: code = 4'd9;
         7'b110_1101: code = 4'd6;
         7'b110_1110: code = 4'd3;
         7'b101_0111: code = 4'd0;
         7'b101_1011: code = 4'd8;
         7'b101_1101: code = 4'd5;
         7'b101_1110: code = 4'd2;
         7'b011_0111: code = 4'd10;
         7'b011_1011: code = 4'd7;
         7'b011_1101: code = 4'd4;
         7'b011_1110: code = 4'd1;
         default:     code = 4'd0;
      endcase
      return code;
   endfunction

   always_comb begin
      row_s1_d     = row;
      row_s2_d     = row_s1_q;
      cnt_d        = cnt_q;
      column_d     = column_q;
      acc_res_d    = acc_res_q;
      acc_code_d   = acc_code_q;
      frame_done_d = 1'b0;
      prev_res_d   = prev_res_q;
      prev_code_d  = prev_code_q;
      stab_d       = stab_q;
      state_d      = state_q;
      key_code_d   = key_code_q;
      key_valid_d  = 1'b0;
      key_held_d   = key_held_q;
      key_error_d  = 1'b0;
      match        = 1'b0;
      evt          = 1'b0;

      case (row_s2_q)
         4'b1111:                            samp_res = RES_NONE;
         4'b0111, 4'b1011, 4'b1101, 4'b1110: samp_res = RES_SINGLE;
         default:                            samp_res = RES_MULTI;
      endcase
      samp_code = key_map(column_q, row_s2_q);
      base_res  = (column_q == COL_A) ? RES_NONE : acc_res_q;

      if (!scan_en) begin
         column_d    = COL_OFF;
         cnt_d       = '0;
         acc_res_d   = RES_NONE;
         acc_code_d  = '0;
         prev_res_d  = RES_NONE;
         prev_code_d = '0;
         stab_d      = '0;
         state_d     = IDLE;
         key_held_d  = 1'b0;
      end else if (column_q == COL_OFF) begin
         // first enabled cycle after parking: start a fresh frame on column 110
         column_d = COL_A;
         cnt_d    = '0;
      end else begin
         if (cnt_q == CW'(SCAN_DIV - 1)) begin
            cnt_d        = '0;
            column_d     = {column_q[1:0], column_q[2]};
            frame_done_d = (column_q == COL_C);
            if (samp_res == RES_MULTI || (samp_res == RES_SINGLE && base_res != RES_NONE)) begin
               acc_res_d  = RES_MULTI;
               acc_code_d = '0;
            end else if (samp_res == RES_SINGLE) begin
               acc_res_d  = RES_SINGLE;
               acc_code_d = samp_code;
            end else begin
               acc_res_d  = base_res;
               acc_code_d = (column_q == COL_A) ? 4'd0 : acc_code_q;
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
         end

         if (frame_done_q) begin
            match = (acc_res_q == prev_res_q) && (acc_code_q == prev_code_q);
            if (match) begin
               if (stab_q != DB) stab_d = stab_q + 4'd1;
               evt = (stab_q == DB - 4'd1);
            end else begin
               stab_d      = 4'd1;
               evt         = (DB == 4'd1);
               prev_res_d  = acc_res_q;
               prev_code_d = acc_code_q;
            end

            if (evt) begin
               case (state_q)
                  IDLE: begin
                     if (acc_res_q == RES_SINGLE) begin
                        key_code_d  = acc_code_q;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        state_d     = PRESSED;
                     end else if (acc_res_q == RES_MULTI) begin
                        key_error_d = 1'b1;
                        state_d     = BLOCKED;
                     end
                  end
                  PRESSED: begin
                     if (acc_res_q == RES_NONE) begin
                        key_held_d = 1'b0;
                        state_d    = IDLE;
                     end else if (acc_res_q == RES_MULTI || acc_code_q != key_code_q) begin
                        key_held_d = 1'b0;
                        state_d    = BLOCKED;
                     end
                  end
                  BLOCKED: begin
                     if (acc_res_q == RES_NONE) state_d = IDLE;
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_s1_q     <= 4'b1111;
         row_s2_q     <= 4'b1111;
         cnt_q        <= '0;
         column_q     <= COL_A;
         acc_res_q    <= RES_NONE;
         acc_code_q   <= '0;
         frame_done_q <= 1'b0;
         prev_res_q   <= RES_NONE;
         prev_code_q  <= '0;
         stab_q       <= '0;
         state_q      <= IDLE;
         key_code_q   <= '0;
         key_valid_q  <= 1'b0;
         key_held_q   <= 1'b0;
         key_error_q  <= 1'b0;
      end else begin
         row_s1_q     <= row_s1_d;
         row_s2_q     <= row_s2_d;
         cnt_q        <= cnt_d;
         column_q     <= column_d;
         acc_res_q    <= acc_res_d;
         acc_code_q   <= acc_code_d;
         frame_done_q <= frame_done_d;
         prev_res_q   <= prev_res_d;
         prev_code_q  <= prev_code_d;
         stab_q       <= stab_d;
         state_q      <= state_d;
         key_code_q   <= key_code_d;
         key_valid_q  <= key_valid_d;
         key_held_q   <= key_held_d;
         key_error_q  <= key_error_d;
      end
   end

   assign column    = column_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
   assign key_error = key_error_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a simulated keypad answers the column drive, and a
// frame-level reference model predicts every output on every cycle.
module tb_keypad_scan_ctrl;
   localparam int SD      = 4;
   localparam int DB      = 2;
   localparam int R_NONE  = -1;
   localparam int R_MULTI = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scan_en = 1'b1;
   logic [3:0] row;
   logic [2:0] column;
   logic [3:0] key_code;
   logic       key_valid, key_held, key_error;

   keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .clk(clk), .rst(rst), .scan_en(scan_en), .row(row), .column(column),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .key_error(key_error)
   );

   always #5 clk = ~clk;

   // key_at[column index][row bit]; column index 0 is drive 110
   int         key_at [3][4] = '{'{3, 6, 9, 11}, '{2, 5, 8, 0}, '{1, 4, 7, 10}};
   logic [11:0] keys_down = '0;

   always_comb begin
      row = 4'b1111;
      for (int c = 0; c < 3; c++)
         if (column[c] == 1'b0)
            for (int b = 0; b < 4; b++)
               if (keys_down[key_at[c][b]]) row[b] = 1'b0;
   end

   int gcyc;
   always @(posedge clk or negedge rst)
      if (!rst) gcyc <= 0;
      else      gcyc <= gcyc + 1;

   int          nvec = 0, nerr = 0;
   int          hist[$];
   int          m_state;
   logic        m_held, m_nxt_held, m_nxt_vld, m_nxt_err;
   logic [3:0]  m_code, m_nxt_code;
   int          vld_seen = 0, err_seen = 0, last_vld_cyc = -1;

   function automatic logic [11:0] kb(input int c);
      return 12'(1) << c;
   endfunction

   function automatic int frame_result(input logic [11:0] k);
      int n, idx;
      n = 0; idx = 0;
      for (int i = 0; i < 12; i++) if (k[i]) begin n++; idx = i; end
      if (n == 0) return R_NONE;
      if (n > 1)  return R_MULTI;
      return idx;
   endfunction

   task automatic model_reset(input bit keep_code);
      hist.delete();
      m_state = 0; m_held = 1'b0; m_nxt_held = 1'b0;
      m_nxt_vld = 1'b0; m_nxt_err = 1'b0;
      if (!keep_code) m_code = 4'd0;
      m_nxt_code = m_code;
   endtask

   // An event is the frame whose run of identical results reaches exactly DB long.
   task automatic model_frame(input int r);
      int run;
      hist.push_back(r);
      run = 0;
      for (int i = hist.size() - 1; i >= 0 && hist[i] == r; i--) run++;
      m_nxt_held = m_held; m_nxt_code = m_code; m_nxt_vld = 1'b0; m_nxt_err = 1'b0;
      if (run == DB) begin
         if (m_state == 0) begin
            if (r >= 0 && r < 12) begin
               m_nxt_vld = 1'b1; m_nxt_code = 4'(r); m_nxt_held = 1'b1; m_state = 1;
            end else if (r == R_MULTI) begin
               m_nxt_err = 1'b1; m_state = 2;
            end
         end else if (m_state == 1) begin
            if (r == R_NONE) begin
               m_nxt_held = 1'b0; m_state = 0;
            end else if (r == R_MULTI || r != int'(m_code)) begin
               m_nxt_held = 1'b0; m_state = 2;
            end
         end else if (r == R_NONE) begin
            m_state = 0;
         end
      end
   endtask

   // Entered at the falling edge in the first cycle of a frame (column 110, dwell 0).
   task automatic run_frame(input logic [11:0] keys, input int ncyc);
      logic       exp_v, exp_e;
      logic [2:0] exp_col;
      keys_down = keys;
      for (int c = 0; c < ncyc; c++) begin
         exp_v = 1'b0; exp_e = 1'b0;
         if (c == 1) begin
            m_held = m_nxt_held; m_code = m_nxt_code;
            exp_v = m_nxt_vld; exp_e = m_nxt_err;
            m_nxt_vld = 1'b0; m_nxt_err = 1'b0;
         end
         exp_col = (c < SD) ? 3'b110 : (c < 2 * SD) ? 3'b101 : 3'b011;
         nvec++;
         if (column !== exp_col) begin
            nerr++; $display("FAIL column c=%0d: got %b want %b", c, column, exp_col);
         end
         nvec++;
         if (key_valid !== exp_v) begin
            nerr++; $display("FAIL key_valid c=%0d cyc=%0d: got %b want %b", c, gcyc, key_valid, exp_v);
         end
         nvec++;
         if (key_error !== exp_e) begin
            nerr++; $display("FAIL key_error c=%0d cyc=%0d: got %b want %b", c, gcyc, key_error, exp_e);
         end
         nvec++;
         if (key_held !== m_held) begin
            nerr++; $display("FAIL key_held c=%0d cyc=%0d: got %b want %b", c, gcyc, key_held, m_held);
         end
         nvec++;
         if (key_code !== m_code) begin
            nerr++; $display("FAIL key_code c=%0d cyc=%0d: got %0d want %0d", c, gcyc, key_code, m_code);
         end
         if (key_valid === 1'b1) begin vld_seen++; last_vld_cyc = gcyc; end
         if (key_error === 1'b1) err_seen++;
         @(negedge clk);
      end
      if (ncyc == 3 * SD) model_frame(frame_result(keys));
   endtask

   task automatic frames(input logic [11:0] keys, input int n);
      for (int i = 0; i < n; i++) run_frame(keys, 3 * SD);
   endtask

   task automatic check_outputs_reset(input string tag);
      nvec++;
      if ({column, key_code, key_valid, key_held, key_error} !== {3'b110, 4'd0, 3'b000}) begin
         nerr++;
         $display("FAIL %s: got col=%b code=%0d v=%b h=%b e=%b want col=110 code=0 v=0 h=0 e=0",
                  tag, column, key_code, key_valid, key_held, key_error);
      end
   endtask

   task automatic test_reset();
      scan_en = 1'b1; keys_down = '0;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_reset("reset_values");
      rst = 1'b1;
      model_reset(1'b0);
   endtask

   task automatic test_press();
      int v0;
      v0 = vld_seen;
      frames(kb(5), 3);
      nvec++;
      if (vld_seen !== v0 + 1) begin nerr++; $display("FAIL press5_pulses: got %0d want %0d", vld_seen - v0, 1); end
      nvec++;
      if (last_vld_cyc !== 25) begin nerr++; $display("FAIL press5_latency: got cycle %0d want 25", last_vld_cyc); end
      nvec++;
      if (key_code !== 4'd5 || key_held !== 1'b1) begin
         nerr++; $display("FAIL press5_state: got code=%0d held=%b want 5/1", key_code, key_held);
      end
      frames('0, 3);
      nvec++;
      if (key_held !== 1'b0 || vld_seen !== v0 + 1) begin
         nerr++; $display("FAIL release5: got held=%b pulses=%0d want 0/1", key_held, vld_seen - v0);
      end
      frames(kb(11), 3);
      nvec++;
      if (vld_seen !== v0 + 2 || key_code !== 4'd11) begin
         nerr++; $display("FAIL press_hash: got pulses=%0d code=%0d want 2/11", vld_seen - v0, key_code);
      end
      frames('0, 3);
   endtask

   task automatic test_multi();
      int v0, e0;
      v0 = vld_seen; e0 = err_seen;
      frames(kb(1) | kb(3), 3);
      nvec++;
      if (err_seen !== e0 + 1 || vld_seen !== v0) begin
         nerr++; $display("FAIL multi_pulses: got err=%0d vld=%0d want 1/0", err_seen - e0, vld_seen - v0);
      end
      nvec++;
      if (key_code !== 4'd11) begin nerr++; $display("FAIL multi_code_kept: got %0d want 11", key_code); end
      frames('0, 3);
   endtask

   task automatic test_bounce();
      int v0;
      v0 = vld_seen;
      for (int i = 0; i < 10; i++) run_frame((i % 2 == 0) ? kb(8) : 12'd0, 3 * SD);
      nvec++;
      if (vld_seen !== v0 || key_held !== 1'b0) begin
         nerr++; $display("FAIL bounce: got pulses=%0d held=%b want 0/0", vld_seen - v0, key_held);
      end
      frames('0, 3);
   endtask

   task automatic test_scan_en();
      int v0;
      frames(kb(2), 1);
      run_frame(kb(2), 5);
      v0 = vld_seen;
      scan_en = 1'b0;
      @(negedge clk);
      nvec++;
      if (column !== 3'b111) begin nerr++; $display("FAIL park_column: got %b want 111", column); end
      for (int i = 0; i < 6; i++) begin
         nvec++;
         if (column !== 3'b111 || key_valid !== 1'b0 || key_error !== 1'b0 || key_held !== 1'b0 || key_code !== 4'd11) begin
            nerr++;
            $display("FAIL parked: got col=%b v=%b e=%b h=%b code=%0d want 111/0/0/0/11",
                     column, key_valid, key_error, key_held, key_code);
         end
         @(negedge clk);
      end
      model_reset(1'b1);
      scan_en = 1'b1;
      @(negedge clk);
      frames(kb(2), 2);
      nvec++;
      if (vld_seen !== v0) begin nerr++; $display("FAIL reenable_early: got pulses=%0d want 0", vld_seen - v0); end
      frames(kb(2), 1);
      nvec++;
      if (vld_seen !== v0 + 1 || key_code !== 4'd2) begin
         nerr++; $display("FAIL reenable_press: got pulses=%0d code=%0d want 1/2", vld_seen - v0, key_code);
      end
      frames('0, 3);
   endtask

   task automatic test_async_reset();
      int v0;
      frames(kb(7), 3);
      run_frame(kb(7), 6);
      #2 rst = 1'b0;
      #1 check_outputs_reset("async_reset");
      @(negedge clk);
      rst = 1'b1;
      model_reset(1'b0);
      v0 = vld_seen;
      frames(kb(7), 3);
      nvec++;
      if (vld_seen !== v0 + 1 || key_code !== 4'd7 || key_held !== 1'b1) begin
         nerr++; $display("FAIL post_reset_press: got pulses=%0d code=%0d held=%b want 1/7/1",
                          vld_seen - v0, key_code, key_held);
      end
      frames('0, 3);
   endtask

   task automatic test_random();
      logic [11:0] keys;
      int p, a, b;
      keys = '0;
      for (int f = 0; f < 40; f++) begin
         p = $urandom_range(0, 9);
         if (p >= 4 && p <= 5) keys = '0;
         else if (p >= 6 && p <= 8) keys = kb($urandom_range(0, 11));
         else if (p == 9) begin
            a = $urandom_range(0, 11);
            b = (a + $urandom_range(1, 11)) % 12;
            keys = kb(a) | kb(b);
         end
         run_frame(keys, 3 * SD);
      end
      frames('0, 3);
   endtask

   initial begin
      test_reset();
      test_press();
      test_multi();
      test_bounce();
      test_scan_en();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
